// File: rtl/rc4_search_controller.sv
// Brute-force RC4 key search sequencer: requests a candidate key, launches the
// decrypt/check core with it, and stops on match, exhaustion, abort or timeout.
module rc4_search_controller #(
    parameter int unsigned      KEY_W       = 24,
    parameter logic [KEY_W-1:0] KEY_MAX     = KEY_W'(24'h3FFFFF),
    parameter int unsigned      TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             search_start,
    input  logic             search_abort,
    output logic             key_req,
    input  logic             key_ack,
    input  logic [KEY_W-1:0] key_in,
    output logic             core_start,
    output logic [KEY_W-1:0] core_key,
    input  logic             core_done,
    input  logic             core_match,
    output logic             busy,
    output logic             found,
    output logic [KEY_W-1:0] found_key,
    output logic             exhausted,
    output logic             timeout_err,
    output logic [KEY_W-1:0] attempts
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_KEY,
        S_WAIT_KEY,
        S_LAUNCH,
        S_WAIT_CORE,
        S_FOUND,
        S_EXHAUSTED,
        S_ERROR
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [TW-1:0]   timer;
    logic            timer_exp;
    logic            start_ok;
    logic            key_take;
    logic            done_take;
    logic            to_set;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        start_ok   = 1'b0;
        key_take   = 1'b0;
        done_take  = 1'b0;
        to_set     = 1'b0;
        key_req    = 1'b0;
        core_start = 1'b0;
        busy       = 1'b0;
        // Expiry is flagged on the last permitted waiting cycle so that the
        // wait lasts exactly TIMEOUT_CYC cycles.
        timer_exp  = (timer == TW'(TIMEOUT_CYC - 1));
        case (state)
            S_IDLE, S_FOUND, S_EXHAUSTED, S_ERROR: begin
                if (search_start) begin
                    start_ok = 1'b1;
                    state_n  = S_REQ_KEY;
                end
            end
            S_REQ_KEY: begin
                key_req = 1'b1;
                busy    = 1'b1;
                state_n = S_WAIT_KEY;
            end
            S_WAIT_KEY: begin
                busy = 1'b1;
                if (key_ack) begin
                    key_take = 1'b1;
                    state_n  = S_LAUNCH;
                end else if (timer_exp) begin
                    to_set  = 1'b1;
                    state_n = S_ERROR;
                end
            end
            S_LAUNCH: begin
                core_start = 1'b1;
                busy       = 1'b1;
                state_n    = S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
                busy = 1'b1;
                if (core_done) begin
                    done_take = 1'b1;
                    if (core_match) begin
                        state_n = S_FOUND;
                    end else if (core_key == KEY_MAX) begin
                        state_n = S_EXHAUSTED;
                    end else begin
                        state_n = S_REQ_KEY;
                    end
                end else if (timer_exp) begin
                    to_set  = 1'b1;
                    state_n = S_ERROR;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (search_abort) begin
            state_n   = S_IDLE;
            start_ok  = 1'b0;
            key_take  = 1'b0;
            done_take = 1'b0;
            to_set    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer       <= '0;
            core_key    <= '0;
            found       <= 1'b0;
            found_key   <= '0;
            exhausted   <= 1'b0;
            timeout_err <= 1'b0;
            attempts    <= '0;
        end else begin
            if (state == S_REQ_KEY || state == S_LAUNCH) begin
                timer <= '0;
            end else if (state == S_WAIT_KEY || state == S_WAIT_CORE) begin
                timer <= timer + 1'b1;
            end

            if (search_abort) begin
                found       <= 1'b0;
                exhausted   <= 1'b0;
                timeout_err <= 1'b0;
            end else begin
                if (start_ok) begin
                    found       <= 1'b0;
                    exhausted   <= 1'b0;
                    timeout_err <= 1'b0;
                    attempts    <= '0;
                    found_key   <= '0;
                end
                if (key_take) begin
                    core_key <= key_in;
                end
                if (done_take) begin
                    if (attempts != '1) begin
                        attempts <= attempts + KEY_W'(1);
                    end
                    if (core_match) begin
                        found     <= 1'b1;
                        found_key <= core_key;
                    end else if (core_key == KEY_MAX) begin
                        exhausted <= 1'b1;
                    end
                end
                if (to_set) begin
                    timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rc4_search_controller.sv
// Directed bench for rc4_search_controller with key-generator and core models;
// acked keys are queued and checked against core_key at each core_start.
module tb_rc4_search_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        search_start = 1'b0;
    logic        search_abort = 1'b0;
    logic        key_req;
    logic        key_ack = 1'b0;
    logic [23:0] key_in = '0;
    logic        core_start;
    logic [23:0] core_key;
    logic        core_done = 1'b0;
    logic        core_match = 1'b0;
    logic        busy;
    logic        found;
    logic [23:0] found_key;
    logic        exhausted;
    logic        timeout_err;
    logic [23:0] attempts;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    rc4_search_controller #(
        .KEY_W(24),
        .KEY_MAX(24'h00002A),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .reset(reset),
        .search_start(search_start), .search_abort(search_abort),
        .key_req(key_req), .key_ack(key_ack), .key_in(key_in),
        .core_start(core_start), .core_key(core_key),
        .core_done(core_done), .core_match(core_match),
        .busy(busy), .found(found), .found_key(found_key),
        .exhausted(exhausted), .timeout_err(timeout_err), .attempts(attempts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // key generator model
    logic [23:0] exp_keys[$];
    logic [23:0] gen_next = 24'd1;
    logic [23:0] last_key = '0;
    int          gen_dly = 1;
    bit          gen_en = 1'b1;
    int          gen_cnt = -1;
    int          ack_cyc = 0;

    always @(negedge clk) begin
        key_ack = 1'b0;
        if (!reset) begin
            gen_cnt = -1;
        end else begin
            if (gen_cnt > 0) begin
                gen_cnt--;
            end else if (gen_cnt == 0) begin
                key_ack = 1'b1;
                key_in  = gen_next;
                exp_keys.push_back(gen_next);
                last_key = gen_next;
                ack_cyc  = cyc;
                gen_next = gen_next + 24'd1;
                gen_cnt  = -1;
            end
            if (key_req && gen_en) gen_cnt = gen_dly - 1;
        end
    end

    // RC4 core model
    logic [23:0] match_key = '0;
    logic [23:0] core_keyq = '0;
    int          core_dly = 1;
    bit          core_en = 1'b1;
    int          core_cnt = -1;
    int          done_cnt = 0;
    int          nomatch_cyc = 0;
    bit          nomatch_chk = 1'b0;

    always @(negedge clk) begin
        core_done  = 1'b0;
        core_match = 1'b0;
        if (!reset) begin
            core_cnt = -1;
        end else begin
            if (core_cnt > 0) begin
                core_cnt--;
            end else if (core_cnt == 0) begin
                core_done  = 1'b1;
                core_match = (core_keyq == match_key);
                done_cnt++;
                if (!core_match) begin
                    nomatch_cyc = cyc;
                    nomatch_chk = 1'b1;
                end
                core_cnt = -1;
            end
            if (core_start && core_en) begin
                core_cnt  = core_dly - 1;
                core_keyq = last_key;
            end
        end
    end

    // scoreboard / latency monitor
    int req_cnt = 0;
    always @(negedge clk) begin
        if (reset) begin
            if (core_start) begin
                if (exp_keys.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL sb_underflow observed=core_start expected=no_start");
                end else begin
                    chk("core_key", 32'(core_key), 32'(exp_keys.pop_front()));
                end
                chk("ack_to_start", cyc, ack_cyc + 1);
            end
            if (key_req) begin
                req_cnt++;
                if (nomatch_chk) begin
                    chk("done_to_req", cyc, nomatch_cyc + 1);
                    nomatch_chk = 1'b0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic go();
        search_start = 1'b1;
        nomatch_chk  = 1'b0;
        @(negedge clk);
        search_start = 1'b0;
    endtask

    task automatic wait_not_busy(input string tag, input int max);
        int n = 0;
        while (busy === 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;

        tick(3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", 32'({found, exhausted, timeout_err, key_req, core_start}), 32'd0);
        chk("rst_attempts", 32'(attempts), 32'd0);
        chk("rst_core_key", 32'(core_key), 32'd0);
        chk("rst_found_key", 32'(found_key), 32'd0);
        #2 reset = 1'b1;
        tick(2);

        // first key 1, match on 0x2A which is also KEY_MAX (found wins)
        gen_next = 24'd1; gen_dly = 1; core_dly = 2; match_key = 24'h00002A;
        go();
        chk("start_to_req", 32'(key_req), 32'd1);
        wait_not_busy("match_end", 2000);
        chk("match_found", 32'(found), 32'd1);
        chk("match_found_key", 32'(found_key), 32'h2A);
        chk("match_attempts", 32'(attempts), 32'd42);
        chk("match_not_exh", 32'(exhausted), 32'd0);
        tick(10);
        chk("match_no_more_req", req_cnt, 42);
        chk("match_sb_empty", exp_keys.size(), 0);

        // exhaustion: keys 39..42, none match
        gen_next = 24'd39; match_key = 24'd0;
        go();
        chk("exh_clears_found", 32'(found), 32'd0);
        wait_not_busy("exh_end", 500);
        chk("exh_flag", 32'(exhausted), 32'd1);
        chk("exh_found", 32'(found), 32'd0);
        chk("exh_found_key", 32'(found_key), 32'd0);
        chk("exh_attempts", 32'(attempts), 32'd4);
        chk("exh_req_cnt", req_cnt, 46);

        // core never answers: 16 waiting cycles then ERROR
        core_en = 1'b0; gen_next = 24'd100;
        go();
        n = 0;
        while (core_start !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        chk("tcore_launched", 32'(core_start), 32'd1);
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        chk("tcore_wait_cycles", n, 16);
        chk("tcore_flag", 32'(timeout_err), 32'd1);
        chk("tcore_exh_clear", 32'(exhausted), 32'd0);
        chk("tcore_attempts", 32'(attempts), 32'd0);
        core_en = 1'b1;

        // generator never acks
        gen_en = 1'b0;
        go();
        chk("tkey_clears_err", 32'(timeout_err), 32'd0);
        n = 0;
        @(negedge clk);
        while (busy === 1'b1 && n < 100) begin n++; @(negedge clk); end
        chk("tkey_wait_cycles", n, 16);
        chk("tkey_flag", 32'(timeout_err), 32'd1);
        gen_en = 1'b1;

        // ack lands on the expiry cycle: ack wins
        gen_dly = 16; gen_next = 24'd7; match_key = 24'd7; core_dly = 1;
        go();
        wait_not_busy("ackwin_end", 200);
        chk("ackwin_found", 32'(found), 32'd1);
        chk("ackwin_no_err", 32'(timeout_err), 32'd0);
        chk("ackwin_key", 32'(found_key), 32'd7);

        // abort + start together during WAIT_CORE after two attempts
        gen_dly = 1; core_dly = 6; gen_next = 24'd200; match_key = 24'd0;
        d0 = done_cnt;
        go();
        n = 0;
        while (!((done_cnt - d0) >= 2 && core_start === 1'b1) && n < 200) begin
            @(negedge clk); n++;
        end
        chk("abort_third_launch", 32'(core_start), 32'd1);
        @(negedge clk);
        search_abort = 1'b1;
        search_start = 1'b1;
        @(negedge clk);
        search_abort = 1'b0;
        search_start = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_flags", 32'({found, exhausted, timeout_err}), 32'd0);
        chk("abort_core_key", 32'(core_key), 32'd202);
        tick(10);
        chk("abort_late_done_sent", done_cnt - d0, 3);
        chk("abort_attempts", 32'(attempts), 32'd2);
        chk("abort_still_idle", 32'(busy), 32'd0);
        chk("abort_no_req", 32'(key_req), 32'd0);

        // asynchronous reset while waiting for a key
        gen_dly = 12; gen_next = 24'd60;
        go();
        tick(3);
        chk("rst6_waiting", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rst6_busy", 32'(busy), 32'd0);
        chk("rst6_core_key", 32'(core_key), 32'd0);
        chk("rst6_outs", 32'({found, exhausted, timeout_err, key_req, core_start}), 32'd0);
        chk("rst6_attempts", 32'(attempts), 32'd0);
        @(negedge clk);
        exp_keys.delete();
        #2 reset = 1'b1;
        gen_dly = 1; core_dly = 1; gen_next = 24'd1; match_key = 24'd3;
        tick(2);
        go();
        wait_not_busy("rst6_restart_end", 200);
        chk("rst6_restart_found", 32'(found), 32'd1);
        chk("rst6_restart_key", 32'(found_key), 32'd3);
        chk("rst6_restart_attempts", 32'(attempts), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
